// File: rtl/dac_tlv5618_sched.sv
// dac_tlv5618_sched: schedules channel A/B code writes to a TLV5618 serializer.
// B launches before A so the A write (which latches both DAC outputs) completes a pair.
module dac_tlv5618_sched #(
    parameter int SHIFT_CYCLES = 17,
    parameter int GAP_CYCLES   = 4
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Req_A,
    input  logic [11:0] Code_A,
    input  logic        Req_B,
    input  logic [11:0] Code_B,
    input  logic        Clr_Ovr,
    output logic        Out_Cmd_En,
    output logic        Out_Sel_A_B,
    output logic [11:0] Out_Code,
    output logic        Busy,
    output logic        Done_A,
    output logic        Done_B,
    output logic        Pend_A,
    output logic        Pend_B,
    output logic        Ovr_A,
    output logic        Ovr_B
);
    localparam int MAXC = (SHIFT_CYCLES > GAP_CYCLES) ? SHIFT_CYCLES : GAP_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_a_q, pend_b_q, pend_a_d, pend_b_d;
    logic          ovr_a_q, ovr_b_q, ovr_a_d, ovr_b_d;
    logic [11:0]   code_a_q, code_b_q;
    logic          cmd_q, sel_q, done_a_q, done_b_q;
    logic [11:0]   out_code_q;
    logic          launch_a, launch_b, shift_end, gap_end;

    assign shift_end = cnt_q == CW'(SHIFT_CYCLES - 1);
    assign gap_end   = cnt_q == CW'(GAP_CYCLES - 1);
    assign launch_b  = (state_q == IDLE) && pend_b_q;
    assign launch_a  = (state_q == IDLE) && pend_a_q && !pend_b_q;

    always_comb begin
        state_d  = (state_q == IDLE)  ? ((pend_a_q || pend_b_q) ? SHIFT : IDLE) :
                   (state_q == SHIFT) ? (shift_end ? GAP : SHIFT) :
                   (gap_end ? IDLE : GAP);
        cnt_d    = ((state_q == IDLE) || (state_q == SHIFT && shift_end) || (state_q != SHIFT && gap_end))
                   ? '0 : cnt_q + 1'b1;
        // a request in the launch cycle re-arms the entry with the new code
        pend_a_d = Req_A || (pend_a_q && !launch_a);
        pend_b_d = Req_B || (pend_b_q && !launch_b);
        ovr_a_d  = (ovr_a_q && !Clr_Ovr) || (Req_A && pend_a_q && !launch_a);
        ovr_b_d  = (ovr_b_q && !Clr_Ovr) || (Req_B && pend_b_q && !launch_b);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pend_a_q   <= 1'b0;
            pend_b_q   <= 1'b0;
            ovr_a_q    <= 1'b0;
            ovr_b_q    <= 1'b0;
            code_a_q   <= '0;
            code_b_q   <= '0;
            cmd_q      <= 1'b0;
            sel_q      <= 1'b0;
            out_code_q <= '0;
            done_a_q   <= 1'b0;
            done_b_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_a_q   <= pend_a_d;
            pend_b_q   <= pend_b_d;
            ovr_a_q    <= ovr_a_d;
            ovr_b_q    <= ovr_b_d;
            code_a_q   <= Req_A ? Code_A : code_a_q;
            code_b_q   <= Req_B ? Code_B : code_b_q;
            cmd_q      <= launch_a || launch_b;
            sel_q      <= launch_b ? 1'b0 : launch_a ? 1'b1 : sel_q;
            out_code_q <= launch_b ? code_b_q : launch_a ? code_a_q : out_code_q;
            done_a_q   <= (state_q == GAP) && gap_end && sel_q;
            done_b_q   <= (state_q == GAP) && gap_end && !sel_q;
        end
    end

    assign Out_Cmd_En  = cmd_q;
    assign Out_Sel_A_B = sel_q;
    assign Out_Code    = out_code_q;
    assign Busy        = state_q != IDLE;
    assign Done_A      = done_a_q;
    assign Done_B      = done_b_q;
    assign Pend_A      = pend_a_q;
    assign Pend_B      = pend_b_q;
    assign Ovr_A       = ovr_a_q;
    assign Ovr_B       = ovr_b_q;
endmodule
